// File: rtl/option_feeder_if.sv
// option_feeder_if
//   Groups the load-side and stream-side handshake signals of option_feeder.
//   master : the feeder (accepts load beats, drives the option stream)
//   slave  : the environment (option generator + solver)
//   Load  : wr_valid, wr_line, wr_option, wr_ready, load_done
//   Stream: option, valid_op, started, old_options_amnt, put_back_to_FIFO, solved
interface option_feeder_if #(
    parameter int SIZE  = 11,
    parameter int LINES = 2*SIZE,
    parameter int CW    = 7
);
    logic                     wr_valid;
    logic [$clog2(LINES)-1:0] wr_line;
    logic [SIZE-1:0]          wr_option;
    logic                     wr_ready;
    logic                     load_done;
    logic [SIZE-1:0]          option;
    logic                     valid_op;
    logic                     started;
    logic [LINES*CW-1:0]      old_options_amnt;
    logic                     put_back_to_FIFO;
    logic                     solved;

    modport master (
        input  wr_valid, wr_line, wr_option, load_done, put_back_to_FIFO, solved,
        output wr_ready, option, valid_op, started, old_options_amnt
    );
    modport slave (
        output wr_valid, wr_line, wr_option, load_done, put_back_to_FIFO, solved,
        input  wr_ready, option, valid_op, started, old_options_amnt
    );
endinterface

// File: rtl/option_feeder.sv
// option_feeder
//   Holds every candidate option of every line in a circular FIFO and streams
//   them pass by pass (header beat per line, then its option beats). Only the
//   options the solver flags for keeping are re-enqueued for the next pass.
//   Ports: clk, rst (async, active high), num_rows/num_cols (active board
//   size), bus (option_feeder_if.master: load + stream signals), done (sticky
//   finish), stuck (no-progress pass), pass_num (passes started, saturating).
//   Optional macro FEEDER_STALL_DETECT_EN: end with stuck=1 when a pass keeps
//   as many options as it started with.
module option_feeder #(
    parameter int SIZE  = 11,
    parameter int LINES = 2*SIZE,
    parameter int DEPTH = 1024,
    parameter int CW    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            num_rows,
    input  logic [3:0]            num_cols,
    option_feeder_if.master       bus,
    output logic                  done,
    output logic                  stuck,
    output logic [7:0]            pass_num
);
    localparam int LW = $clog2(LINES);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = LW + SIZE;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_LOAD, S_HDR, S_OPT, S_DRAIN, S_DONE} state_e;

    state_e                   st_q, st_d;
    logic [LW-1:0]            l_q, l_d;
    logic [CW-1:0]            k_q, k_d;        // pops issued for the current line
    logic [LINES-1:0][CW-1:0] cnt_q, cnt_d, amnt_q, amnt_d, cnt_inc;
    logic [SIZE-1:0]          opt_q, opt_d;
    logic                     vld_q, vld_d, is_opt_q, is_opt_d, started_q, started_d;
    logic [LW-1:0]            out_line_q, out_line_d;
    logic                     pend_v_q, pend_v_d;
    logic [LW-1:0]            pend_line_q, pend_line_d;
    logic [SIZE-1:0]          pend_opt_q, pend_opt_d;
    logic                     done_q, done_d, stuck_q, stuck_d;
    logic [7:0]               pass_q, pass_d;
    logic [AW:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [EW-1:0]            mem [DEPTH];

    logic                     full, wr_acc, pb, push, pop, adv, hdr0, stall;
    logic [LW-1:0]            push_line, head_line, last_l;
    logic [SIZE-1:0]          push_opt, head_opt;

    assign full      = (wptr_q - rptr_q) == FULL_CNT;
    assign wr_acc    = bus.wr_valid && bus.wr_ready;
    // The pending register describes the beat shown one cycle earlier, which
    // is exactly the beat the solver's keep flag refers to.
    assign pb        = pend_v_q && bus.put_back_to_FIFO && (st_q != S_DONE);
    assign push      = wr_acc || pb;
    assign push_line = wr_acc ? bus.wr_line   : pend_line_q;
    assign push_opt  = wr_acc ? bus.wr_option : pend_opt_q;
    assign {head_line, head_opt} = mem[rptr_q[AW-1:0]];
    assign last_l    = LW'(num_rows) + LW'(num_cols) - 1'b1;

    // Counts including this cycle's push, so snapshots see the last put-back.
    always_comb begin
        cnt_inc = cnt_q;
        if (push && cnt_q[push_line] != '1)
            cnt_inc[push_line] = cnt_q[push_line] + 1'b1;
    end

`ifdef FEEDER_STALL_DETECT_EN
    localparam int SW = CW + LW + 1;
    logic [SW-1:0] sum_cnt, sum_amnt;
    always_comb begin
        sum_cnt  = '0;
        sum_amnt = '0;
        for (int i = 0; i < LINES; i++) begin
            sum_cnt  = sum_cnt  + SW'(cnt_inc[i]);
            sum_amnt = sum_amnt + SW'(amnt_q[i]);
        end
    end
    assign stall = (sum_cnt == sum_amnt);
`else
    assign stall = 1'b0;
`endif

    // Next-state logic also decides the registered beat shown next cycle.
    always_comb begin
        st_d        = st_q;
        l_d         = l_q;
        k_d         = k_q;
        cnt_d       = cnt_inc;
        amnt_d      = amnt_q;
        opt_d       = '0;
        vld_d       = 1'b0;
        is_opt_d    = 1'b0;
        out_line_d  = '0;
        started_d   = 1'b0;
        done_d      = done_q;
        stuck_d     = stuck_q;
        pass_d      = pass_q;
        pend_v_d    = vld_q && is_opt_q;
        pend_line_d = out_line_q;
        pend_opt_d  = opt_q;
        pop         = 1'b0;
        adv         = 1'b0;
        hdr0        = 1'b0;
        case (st_q)
            S_LOAD: if (bus.load_done) begin
                amnt_d    = cnt_inc;
                cnt_d     = '0;
                pass_d    = 8'd1;
                started_d = 1'b1;
                hdr0      = 1'b1;
            end
            S_HDR: begin
                if (bus.solved)                  st_d = S_DONE;
                else if (amnt_q[l_q] != '0)      begin pop = 1'b1; k_d = CW'(1); end
                else                             adv = 1'b1;
            end
            S_OPT: begin
                if (bus.solved)                  st_d = S_DONE;
                else if (k_q != amnt_q[l_q])     begin pop = 1'b1; k_d = k_q + 1'b1; end
                else                             adv = 1'b1;
            end
            S_DRAIN: begin
                if (bus.solved)                  st_d = S_DONE;
                else if (stall)                  begin st_d = S_DONE; stuck_d = 1'b1; end
                else begin
                    amnt_d = cnt_inc;
                    cnt_d  = '0;
                    pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
                    hdr0   = 1'b1;
                end
            end
            default: ;
        endcase
        if (adv) begin
            if (l_q >= last_l) st_d = S_DRAIN;
            else begin
                st_d  = S_HDR;
                l_d   = l_q + 1'b1;
                vld_d = 1'b1;
                opt_d = SIZE'(l_d);
            end
        end
        if (hdr0) begin
            st_d  = S_HDR;
            l_d   = '0;
            vld_d = 1'b1;
            opt_d = '0;
        end
        if (pop) begin
            st_d       = S_OPT;
            vld_d      = 1'b1;
            is_opt_d   = 1'b1;
            opt_d      = head_opt;
            out_line_d = head_line;
        end
        if (st_d == S_DONE) done_d = 1'b1;
        if (st_q == S_LOAD) pend_v_d = 1'b0;
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= S_LOAD;
            l_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            amnt_q      <= '0;
            opt_q       <= '0;
            vld_q       <= 1'b0;
            is_opt_q    <= 1'b0;
            out_line_q  <= '0;
            started_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_line_q <= '0;
            pend_opt_q  <= '0;
            done_q      <= 1'b0;
            stuck_q     <= 1'b0;
            pass_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            st_q        <= st_d;
            l_q         <= l_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            amnt_q      <= amnt_d;
            opt_q       <= opt_d;
            vld_q       <= vld_d;
            is_opt_q    <= is_opt_d;
            out_line_q  <= out_line_d;
            started_q   <= started_d;
            pend_v_q    <= pend_v_d;
            pend_line_q <= pend_line_d;
            pend_opt_q  <= pend_opt_d;
            done_q      <= done_d;
            stuck_q     <= stuck_d;
            pass_q      <= pass_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= {push_line, push_opt};
    end

    assign bus.wr_ready         = (st_q == S_LOAD) && !full;
    assign bus.option           = opt_q;
    assign bus.valid_op         = vld_q;
    assign bus.started          = started_q;
    assign bus.old_options_amnt = amnt_q;
    assign done                 = done_q;
    assign stuck                = stuck_q;
    assign pass_num             = pass_q;
endmodule

// File: tb/tb_option_feeder.sv
module tb_option_feeder;
    localparam int SIZE = 11;
    localparam int LINES = 22;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] num_rows = 4'd3, num_cols = 4'd3;
    logic [3:0] num_rows4 = 4'd1, num_cols4 = 4'd0;
    logic done, stuck, done4, stuck4;
    logic [7:0] pass_num, pass_num4;

    option_feeder_if #(.SIZE(SIZE), .LINES(LINES), .CW(CW)) bus ();
    option_feeder_if #(.SIZE(SIZE), .LINES(LINES), .CW(CW)) bus4 ();

    option_feeder #(.SIZE(SIZE), .LINES(LINES), .DEPTH(1024), .CW(CW)) dut (
        .clk(clk), .rst(rst), .num_rows(num_rows), .num_cols(num_cols),
        .bus(bus), .done(done), .stuck(stuck), .pass_num(pass_num));

    option_feeder #(.SIZE(SIZE), .LINES(LINES), .DEPTH(4), .CW(CW)) dut4 (
        .clk(clk), .rst(rst), .num_rows(num_rows4), .num_cols(num_cols4),
        .bus(bus4), .done(done4), .stuck(stuck4), .pass_num(pass_num4));

    always #5 clk = ~clk;

    typedef struct {
        logic            keep;    // keep flag for this row's beat (applied next cycle)
        logic            solved;
        logic            vld;
        logic [SIZE-1:0] opt;
        logic            done;
    } vec_t;

    vec_t vt[31];
    int   ld_line[12] = '{0, 0, 1, 1, 1, 2, 3, 4, 4, 5, 5, 5};
    int   ld_opt[12]  = '{6, 3, 4, 2, 1, 5, 5, 6, 3, 4, 2, 1};
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] mk_amnt(input int c0, c1, c2, c3, c4, c5);
        logic [159:0] r;
        int c[6];
        c = '{c0, c1, c2, c3, c4, c5};
        r = '0;
        for (int i = 0; i < 6; i++) r[i*CW +: CW] = CW'(c[i]);
        return r;
    endfunction

    task automatic clear_inputs();
        bus.wr_valid = 1'b0; bus.wr_line = '0; bus.wr_option = '0; bus.load_done = 1'b0;
        bus.put_back_to_FIFO = 1'b0; bus.solved = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_main();
        for (int i = 0; i < 12; i++) begin
            bus.wr_valid  = 1'b1;
            bus.wr_line   = 5'(ld_line[i]);
            bus.wr_option = SIZE'(ld_opt[i]);
            bus.load_done = (i == 11);
            tick();
        end
        bus.wr_valid  = 1'b0;
        bus.load_done = 1'b0;
    endtask

    // Walk table rows; each row's keep flag is presented in the following cycle.
    task automatic run_rows(input int last, input logic force_keep, input string tag);
        logic prev_keep;
        prev_keep = 1'b0;
        for (int i = 0; i <= last; i++) begin
            bus.put_back_to_FIFO = prev_keep;
            bus.solved = vt[i].solved;
            chk($sformatf("%s row%0d valid_op", tag, i), bus.valid_op, vt[i].vld);
            if (vt[i].vld)
                chk($sformatf("%s row%0d option", tag, i), bus.option, vt[i].opt);
            chk($sformatf("%s row%0d done", tag, i), done, vt[i].done);
            chk($sformatf("%s row%0d started", tag, i), bus.started, i == 0);
            if (i == 0) begin
                chk($sformatf("%s pass1 amnt", tag), bus.old_options_amnt, mk_amnt(2, 3, 1, 1, 2, 3));
                chk($sformatf("%s pass1 num", tag), pass_num, 8'd1);
            end
            if (i == 19 && !force_keep) begin
                chk($sformatf("%s pass2 amnt", tag), bus.old_options_amnt, mk_amnt(2, 3, 0, 0, 1, 1));
                chk($sformatf("%s pass2 num", tag), pass_num, 8'd2);
            end
            prev_keep = force_keep ? vt[i].vld : vt[i].keep;
            tick();
        end
        bus.put_back_to_FIFO = 1'b0;
        bus.solved = 1'b0;
    endtask

    initial begin
        // pass 1: rows 0..17, DRAIN row 18
        vt[0]  = '{0, 0, 1, 0, 0};  vt[1]  = '{1, 0, 1, 6, 0};  vt[2]  = '{1, 0, 1, 3, 0};
        vt[3]  = '{0, 0, 1, 1, 0};  vt[4]  = '{1, 0, 1, 4, 0};  vt[5]  = '{1, 0, 1, 2, 0};
        vt[6]  = '{1, 0, 1, 1, 0};  vt[7]  = '{0, 0, 1, 2, 0};  vt[8]  = '{0, 0, 1, 5, 0};
        vt[9]  = '{0, 0, 1, 3, 0};  vt[10] = '{0, 0, 1, 5, 0};  vt[11] = '{0, 0, 1, 4, 0};
        vt[12] = '{1, 0, 1, 6, 0};  vt[13] = '{0, 0, 1, 3, 0};  vt[14] = '{0, 0, 1, 5, 0};
        vt[15] = '{0, 0, 1, 4, 0};  vt[16] = '{0, 0, 1, 2, 0};  vt[17] = '{1, 0, 1, 1, 0};
        vt[18] = '{0, 0, 0, 0, 0};
        // pass 2: solved on the header of line 4
        vt[19] = '{0, 0, 1, 0, 0};  vt[20] = '{0, 0, 1, 6, 0};  vt[21] = '{0, 0, 1, 3, 0};
        vt[22] = '{0, 0, 1, 1, 0};  vt[23] = '{0, 0, 1, 4, 0};  vt[24] = '{0, 0, 1, 2, 0};
        vt[25] = '{0, 0, 1, 1, 0};  vt[26] = '{0, 0, 1, 2, 0};  vt[27] = '{0, 0, 1, 3, 0};
        vt[28] = '{0, 1, 1, 4, 0};  vt[29] = '{0, 0, 0, 0, 1};  vt[30] = '{0, 0, 0, 0, 1};

        clear_inputs();
        bus4.wr_valid = 1'b0; bus4.wr_line = '0; bus4.wr_option = '0; bus4.load_done = 1'b0;
        bus4.put_back_to_FIFO = 1'b0; bus4.solved = 1'b0;
        tick();
        tick();
        // reset state
        chk("rst option", bus.option, '0);
        chk("rst valid_op", bus.valid_op, 1'b0);
        chk("rst started", bus.started, 1'b0);
        chk("rst amnt", bus.old_options_amnt, '0);
        chk("rst done", done, 1'b0);
        chk("rst stuck", stuck, 1'b0);
        chk("rst pass_num", pass_num, 8'd0);
        chk("rst wr_ready", bus.wr_ready, 1'b1);
        rst = 1'b0;
        tick();

        // load into a 4-entry FIFO: only 4 of 6 beats accepted
        for (int i = 0; i < 6; i++) begin
            bus4.wr_valid  = 1'b1;
            bus4.wr_option = SIZE'(i + 1);
            chk($sformatf("full wr_ready%0d", i), bus4.wr_ready, i < 4);
            tick();
        end
        bus4.wr_valid  = 1'b0;
        bus4.load_done = 1'b1;
        tick();
        bus4.load_done = 1'b0;
        chk("full amnt line0", bus4.old_options_amnt[CW-1:0], 7'd4);
        chk("full hdr valid", bus4.valid_op, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk($sformatf("full beat%0d", j), bus4.option, SIZE'(j));
        end
        tick();
        chk("full no 5th beat", bus4.valid_op, 1'b0);

        // 3x3 load, selective put-back, solved mid pass 2
        load_main();
        run_rows(30, 1'b0, "main");
        chk("main done held", done, 1'b1);
        chk("main stuck", stuck, 1'b0);
        chk("main pass_num", pass_num, 8'd2);
        bus.wr_valid = 1'b1; bus.load_done = 1'b1; bus.put_back_to_FIFO = 1'b1;
        tick();
        tick();
        clear_inputs();
        chk("done ignores inputs valid", bus.valid_op, 1'b0);
        chk("done ignores inputs done", done, 1'b1);

        // keep everything in pass 1, never solved
        do_reset();
        load_main();
        run_rows(18, 1'b1, "stall");
`ifdef FEEDER_STALL_DETECT_EN
        chk("stall stuck", stuck, 1'b1);
        chk("stall done", done, 1'b1);
        chk("stall valid_op", bus.valid_op, 1'b0);
        chk("stall pass_num", pass_num, 8'd1);
`else
        chk("repeat stuck", stuck, 1'b0);
        chk("repeat hdr valid", bus.valid_op, 1'b1);
        chk("repeat hdr option", bus.option, '0);
        chk("repeat pass_num", pass_num, 8'd2);
        chk("repeat amnt", bus.old_options_amnt, mk_amnt(2, 3, 1, 1, 2, 3));
`endif

        // reset while in OPT
        do_reset();
        load_main();
        tick();
        chk("midrst pre option", bus.option, SIZE'(6));
        rst = 1'b1;
        #1;
        chk("midrst option", bus.option, '0);
        chk("midrst valid_op", bus.valid_op, 1'b0);
        chk("midrst amnt", bus.old_options_amnt, '0);
        chk("midrst pass_num", pass_num, 8'd0);
        chk("midrst done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst wr_ready", bus.wr_ready, 1'b1);
        chk("midrst valid after", bus.valid_op, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
